// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic operators: FSM state
// encodings and the default datapath width.
package arith_pkg;

    // Default operand/result width of the arithmetic datapath.
    localparam int ARITH_WIDTH = 4;

    // Common three-state handshake FSM used by the iterative operators.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left by one, trial-subtract
// the divisor from the shifted remainder, keep the difference if it did not
// borrow, otherwise restore the shifted remainder.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    // The remainder entering step k is below 2**(k-1), so its MSB is always
    // zero here; {r, q[MSB]} is therefore the zero-extended shifted remainder.
    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    assign r_shift = {r, q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, d};

    // Select between the trial difference and the restored remainder.
    always_comb begin
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule : div_step

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider behind a start/busy/done handshake.
// One quotient bit per cycle; results are held until the next completion.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             last_step;

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_next),
        .q_next (q_next)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (divisor == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                last_step = (count == LAST_STEP);
                if (last_step) next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Working registers, iteration counter and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the working registers are cleared on reset too, so an
            // abandoned operation leaves nothing stale behind.
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            r_reg <= '0;
            q_reg <= dividend;
            d_reg <= divisor;
            count <= '0;
            // A zero divisor completes immediately with the defined result.
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == ST_RUN) begin
            r_reg <= r_next;
            q_reg <= q_next;
            count <= count + 1'b1;
            if (last_step) begin
                quotient    <= q_next;
                remainder   <= r_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: handshake timing, boundary cases,
// reset abandonment, back-to-back operation and a full operand sweep.
module tb_seq_restoring_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Launch one division from the current negedge and follow it to done.
    // poke > 0 re-asserts start with 1/1 in that cycle of the operation.
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int poke, input string tag);
        logic [WIDTH-1:0] exp_q, exp_r, q0, r0;
        logic             exp_dbz;
        int               exp_lat, exp_busy, lat, busy_n;
        bit               held;
        if (b == 0) begin
            exp_q = '1; exp_r = a; exp_dbz = 1'b1; exp_lat = 1; exp_busy = 0;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0;
            exp_lat = WIDTH + 1; exp_busy = WIDTH;
        end
        q0 = quotient; r0 = remainder; held = 1'b1;
        lat = 0; busy_n = 0;
        dividend = a; divisor = b; start = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            start = (k == poke);
            if (k == poke) begin
                dividend = 4'd1;
                divisor  = 4'd1;
            end
            if (busy) busy_n++;
            if (done) lat = k;
            else if (quotient !== q0 || remainder !== r0) held = 1'b0;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_busy);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_by_zero"}, div_by_zero, exp_dbz);
        check({tag, " held_during_run"}, held, 1);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic operation and timing.
        run_div(4'd13, 4'd3, 0, "13/3");
        @(negedge clk);
        check("done single pulse", done, 0);
        check("idle after done", busy, 0);

        // Assorted operand patterns, back-to-back from each done cycle.
        run_div(4'd15, 4'd1, 0, "15/1");
        run_div(4'd3, 4'd7, 0, "3/7");
        run_div(4'd7, 4'd7, 0, "7/7");
        @(negedge clk);

        // Divide by zero.
        run_div(4'd9, 4'd0, 0, "9/0");
        @(negedge clk);

        // Start during RUN is ignored.
        run_div(4'd12, 4'd5, 2, "12/5 restart ignored");
        @(negedge clk);

        // Reset mid-operation abandons it.
        dividend = 4'd11; divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid-run reset busy", busy, 0);
        check("mid-run reset done", done, 0);
        check("mid-run reset quotient", quotient, 0);
        check("mid-run reset remainder", remainder, 0);
        check("mid-run reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("no done after abandon", saw_done, 0);
        run_div(4'd11, 4'd2, 0, "11/2 after reset");
        @(negedge clk);

        // Back-to-back: new start accepted on the done cycle.
        run_div(4'd14, 4'd4, 0, "14/4");
        run_div(4'd8, 4'd3, 0, "8/3 back-to-back");
        @(negedge clk);

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(WIDTH'(a), WIDTH'(b), 0, $sformatf("sweep %0d/%0d", a, b));
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_restoring_divider
